// File: rtl/avg_threshold_detector_if.sv
// rtl/avg_threshold_detector_if.sv - sample/threshold/status bundle for avg_threshold_detector; THRESH_DURATION_EN adds dur_o
interface avg_threshold_detector_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]  avg_i;
  logic                   avg_valid_i;
  logic [DATA_WIDTH-1:0]  thr_high_i;
  logic [DATA_WIDTH-1:0]  thr_low_i;
  logic                   clear_i;
  logic                   level_o;
  logic                   rise_o;
  logic                   fall_o;
  logic [DATA_WIDTH-1:0]  peak_o;
  logic [COUNT_WIDTH-1:0] event_cnt_o;
  logic                   cfg_err_o;
`ifdef THRESH_DURATION_EN
  logic [15:0]            dur_o;
`endif

  // producer side: drives samples and configuration, observes status
  modport master (
    output avg_i, avg_valid_i, thr_high_i, thr_low_i, clear_i,
`ifdef THRESH_DURATION_EN
    input  dur_o,
`endif
    input  level_o, rise_o, fall_o, peak_o, event_cnt_o, cfg_err_o
  );

  // detector side
  modport slave (
    input  avg_i, avg_valid_i, thr_high_i, thr_low_i, clear_i,
`ifdef THRESH_DURATION_EN
    output dur_o,
`endif
    output level_o, rise_o, fall_o, peak_o, event_cnt_o, cfg_err_o
  );
endinterface

// File: rtl/avg_threshold_detector.sv
// rtl/avg_threshold_detector.sv - hysteresis comparator with N-sample confirmation, peak and rise count; THRESH_DURATION_EN adds high-episode duration
module avg_threshold_detector #(
  parameter int DATA_WIDTH    = 8,
  parameter int CONFIRM_COUNT = 3,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  avg_threshold_detector_if.slave   bus
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_HIGH = 2'd1,
    HIGH      = 2'd2,
    PEND_LOW  = 2'd3
  } state_t;

  localparam logic [3:0] CONFIRM = 4'(CONFIRM_COUNT);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [DATA_WIDTH-1:0]  peak_q, peak_d;
  logic [COUNT_WIDTH-1:0] evt_q, evt_d;
  logic                   cfg_err_q;

  logic                   qual_high;
  logic                   qual_low;
  logic [3:0]             cnt_inc;
  logic [DATA_WIDTH-1:0]  peak_max;
  logic [COUNT_WIDTH-1:0] evt_inc;

`ifdef THRESH_DURATION_EN
  logic [15:0]            dur_cnt_q, dur_cnt_d;
  logic [15:0]            dur_q, dur_d;
  logic [15:0]            dur_inc;
`endif

  assign qual_high = (bus.avg_i >= bus.thr_high_i);
  assign qual_low  = (bus.avg_i <= bus.thr_low_i);
  assign cnt_inc   = cnt_q + 4'd1;
  assign peak_max  = (bus.avg_i > peak_q) ? bus.avg_i : peak_q;
  assign evt_inc   = (&evt_q) ? evt_q : evt_q + COUNT_WIDTH'(1);
`ifdef THRESH_DURATION_EN
  assign dur_inc   = (&dur_cnt_q) ? dur_cnt_q : dur_cnt_q + 16'd1;
`endif

  // next-state: clear beats a config error, which freezes sample processing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    evt_d   = evt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef THRESH_DURATION_EN
    dur_cnt_d = dur_cnt_q;
    dur_d     = dur_q;
`endif
    if (bus.clear_i) begin
      state_d = LOW;
      cnt_d   = 4'd0;
      peak_d  = '0;
      evt_d   = '0;
`ifdef THRESH_DURATION_EN
      dur_cnt_d = 16'd0;
      dur_d     = 16'd0;
`endif
    end else if (!cfg_err_q && bus.avg_valid_i) begin
`ifdef THRESH_DURATION_EN
      // every valid sample consumed while the level is high counts toward the episode
      if (state_q == HIGH || state_q == PEND_LOW) begin
        dur_cnt_d = dur_inc;
      end
`endif
      unique case (state_q)
        LOW: begin
          if (qual_high) begin
            if (CONFIRM == 4'd1) begin
              state_d = HIGH;
              cnt_d   = 4'd0;
            end else begin
              state_d = PEND_HIGH;
              cnt_d   = 4'd1;
            end
          end
        end
        PEND_HIGH: begin
          if (qual_high) begin
            if (cnt_inc == CONFIRM) begin
              state_d = HIGH;
              cnt_d   = 4'd0;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = LOW;
            cnt_d   = 4'd0;
          end
        end
        HIGH: begin
          peak_d = peak_max;
          if (qual_low) begin
            if (CONFIRM == 4'd1) begin
              state_d = LOW;
              cnt_d   = 4'd0;
            end else begin
              state_d = PEND_LOW;
              cnt_d   = 4'd1;
            end
          end
        end
        PEND_LOW: begin
          peak_d = peak_max;
          if (qual_low) begin
            if (cnt_inc == CONFIRM) begin
              state_d = LOW;
              cnt_d   = 4'd0;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = HIGH;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = 4'd0;
        end
      endcase

      // entry to HIGH from the low side: pulse, count, and restart the peak
      if (state_d == HIGH && (state_q == LOW || state_q == PEND_HIGH)) begin
        rise_d = 1'b1;
        evt_d  = evt_inc;
        peak_d = bus.avg_i;
`ifdef THRESH_DURATION_EN
        dur_cnt_d = 16'd0;
`endif
      end

      // entry to LOW from the high side
      if (state_d == LOW && (state_q == HIGH || state_q == PEND_LOW)) begin
        fall_d = 1'b1;
`ifdef THRESH_DURATION_EN
        dur_d  = dur_inc;
`endif
      end
    end
    level_d = (state_d == HIGH) || (state_d == PEND_LOW);
  end

  // state and output registers; the config check runs even during clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOW;
      cnt_q     <= 4'd0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      peak_q    <= '0;
      evt_q     <= '0;
      cfg_err_q <= 1'b0;
`ifdef THRESH_DURATION_EN
      dur_cnt_q <= 16'd0;
      dur_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      peak_q    <= peak_d;
      evt_q     <= evt_d;
      cfg_err_q <= (bus.thr_low_i >= bus.thr_high_i);
`ifdef THRESH_DURATION_EN
      dur_cnt_q <= dur_cnt_d;
      dur_q     <= dur_d;
`endif
    end
  end

  assign bus.level_o     = level_q;
  assign bus.rise_o      = rise_q;
  assign bus.fall_o      = fall_q;
  assign bus.peak_o      = peak_q;
  assign bus.event_cnt_o = evt_q;
  assign bus.cfg_err_o   = cfg_err_q;
`ifdef THRESH_DURATION_EN
  assign bus.dur_o       = dur_q;
`endif

endmodule

// File: tb/tb_avg_threshold_detector.sv
// tb/tb_avg_threshold_detector.sv - directed table-driven bench for avg_threshold_detector
module tb_avg_threshold_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avg_threshold_detector_if #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) bus1 ();
  avg_threshold_detector_if #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) bus2 ();

  avg_threshold_detector #(.DATA_WIDTH(8), .CONFIRM_COUNT(3), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  avg_threshold_detector #(.DATA_WIDTH(8), .CONFIRM_COUNT(3), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  typedef struct {
    logic       v;
    logic [7:0] avg;
    logic [7:0] th;
    logic [7:0] tl;
    logic       clr;
    logic       lvl;
    logic       rise;
    logic       fall;
    logic [7:0] peak;
    logic [7:0] cnt;
    logic       cfg;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  function automatic void add(input logic v, input int avg, input int th, input int tl,
                              input logic clr, input logic lvl, input logic rise,
                              input logic fall, input int peak, input int cnt, input logic cfg);
    vec_t r;
    r.v = v; r.avg = 8'(avg); r.th = 8'(th); r.tl = 8'(tl); r.clr = clr;
    r.lvl = lvl; r.rise = rise; r.fall = fall; r.peak = 8'(peak); r.cnt = 8'(cnt); r.cfg = cfg;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic drive1(input logic v, input logic [7:0] avg, input logic [7:0] th,
                        input logic [7:0] tl, input logic clr);
    @(negedge clk);
    bus1.avg_valid_i = v;
    bus1.avg_i       = avg;
    bus1.thr_high_i  = th;
    bus1.thr_low_i   = tl;
    bus1.clear_i     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic v, input logic [7:0] avg);
    @(negedge clk);
    bus2.avg_valid_i = v;
    bus2.avg_i       = avg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus2.avg_valid_i = 1'b0;
    bus2.avg_i       = 8'd0;
    bus2.thr_high_i  = 8'd100;
    bus2.thr_low_i   = 8'd50;
    bus2.clear_i     = 1'b0;

    // idle after reset
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    // three qualifying samples back-to-back
    add(1,120,100,50,0, 0,0,0,  0,0,0);
    add(1,120,100,50,0, 0,0,0,  0,0,0);
    add(1,130,100,50,0, 1,1,0,130,1,0);
    add(0,  0,100,50,0, 1,0,0,130,1,0);
    // abort of PEND_LOW by 60, then clean fall; peak holds in LOW
    add(1,150,100,50,0, 1,0,0,150,1,0);
    add(1, 40,100,50,0, 1,0,0,150,1,0);
    add(1, 60,100,50,0, 1,0,0,150,1,0);
    add(1, 40,100,50,0, 1,0,0,150,1,0);
    add(1, 40,100,50,0, 1,0,0,150,1,0);
    add(1, 40,100,50,0, 0,0,1,150,1,0);
    add(0,  0,100,50,0, 0,0,0,150,1,0);
    // clear, then pending confirmations across invalid gaps
    add(0,  0,100,50,1, 0,0,0,  0,0,0);
    add(1,120,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(1,120,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(1, 80,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(1,120,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(1,120,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(1,120,100,50,0, 1,1,0,120,1,0);
    add(0,  0,100,50,0, 1,0,0,120,1,0);
    // config error freezes processing, clear during PEND_HIGH
    add(0,  0,100,50,1, 0,0,0,  0,0,0);
    add(0,  0,100,100,0,0,0,0,  0,0,1);
    add(1,200,100,100,0,0,0,0,  0,0,1);
    add(1,200,100,100,0,0,0,0,  0,0,1);
    add(1,200,100,100,0,0,0,0,  0,0,1);
    add(0,  0,100,50,0, 0,0,0,  0,0,0);
    add(1,200,100,50,0, 0,0,0,  0,0,0);
    add(1,200,100,50,0, 0,0,0,  0,0,0);
    add(1,200,100,50,1, 0,0,0,  0,0,0);
    add(1,200,100,50,0, 0,0,0,  0,0,0);
    add(1,200,100,50,0, 0,0,0,  0,0,0);
    add(1,200,100,50,0, 1,1,0,200,1,0);
    // threshold equality boundaries
    add(0,  0,100,50,1, 0,0,0,  0,0,0);
    add(1,100,100,50,0, 0,0,0,  0,0,0);
    add(1,100,100,50,0, 0,0,0,  0,0,0);
    add(1,100,100,50,0, 1,1,0,100,1,0);
    add(1, 51,100,50,0, 1,0,0,100,1,0);
    add(1, 50,100,50,0, 1,0,0,100,1,0);
    add(1, 50,100,50,0, 1,0,0,100,1,0);
    add(1, 50,100,50,0, 0,0,1,100,1,0);
    add(1, 99,100,50,0, 0,0,0,100,1,0);

    // reset held two cycles with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus1.avg_valid_i = 1'($urandom);
      bus1.avg_i       = 8'($urandom);
      bus1.thr_high_i  = 8'($urandom);
      bus1.thr_low_i   = 8'($urandom);
      bus1.clear_i     = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("reset_outputs",
          {12'd0, bus1.level_o, bus1.rise_o, bus1.fall_o, bus1.peak_o, bus1.event_cnt_o, bus1.cfg_err_o},
          32'd0);
`ifdef THRESH_DURATION_EN
    check("reset_dur", {16'd0, bus1.dur_o}, 32'd0);
`endif
    @(negedge clk);
    bus1.avg_valid_i = 1'b0;
    bus1.avg_i       = 8'd0;
    bus1.thr_high_i  = 8'd100;
    bus1.thr_low_i   = 8'd50;
    bus1.clear_i     = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive1(vecs[i].v, vecs[i].avg, vecs[i].th, vecs[i].tl, vecs[i].clr);
      total++;
      if ({bus1.level_o, bus1.rise_o, bus1.fall_o, bus1.peak_o, bus1.event_cnt_o, bus1.cfg_err_o} ===
          {vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].peak, vecs[i].cnt, vecs[i].cfg}) begin
        passed++;
      end else begin
        $display("FAIL vec%0d actual lvl=%b rise=%b fall=%b peak=%0d cnt=%0d cfg=%b required lvl=%b rise=%b fall=%b peak=%0d cnt=%0d cfg=%b",
                 i, bus1.level_o, bus1.rise_o, bus1.fall_o, bus1.peak_o, bus1.event_cnt_o, bus1.cfg_err_o,
                 vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].peak, vecs[i].cnt, vecs[i].cfg);
      end
    end

`ifdef THRESH_DURATION_EN
    // seven valid samples while the level is high: 4 x 150 then 3 x 40
    drive1(0, 8'd0, 8'd100, 8'd50, 1);
    check("dur_after_clear", {16'd0, bus1.dur_o}, 32'd0);
    for (int i = 0; i < 3; i++) drive1(1, 8'd120, 8'd100, 8'd50, 0);
    for (int i = 0; i < 4; i++) drive1(1, 8'd150, 8'd100, 8'd50, 0);
    for (int i = 0; i < 3; i++) drive1(1, 8'd40, 8'd100, 8'd50, 0);
    check("dur_fall_pulse", {31'd0, bus1.fall_o}, 32'd1);
    check("dur_value", {16'd0, bus1.dur_o}, 32'd7);
`endif

    // five rise episodes into a 2-bit counter
    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < 3; i++) drive2(1, 8'd120);
      check($sformatf("sat_rise%0d_level", e), {31'd0, bus2.level_o}, 32'd1);
      check($sformatf("sat_rise%0d_cnt", e), {30'd0, bus2.event_cnt_o}, (e >= 2) ? 32'd3 : 32'(e + 1));
      for (int i = 0; i < 3; i++) drive2(1, 8'd40);
      check($sformatf("sat_fall%0d_level", e), {31'd0, bus2.level_o}, 32'd0);
    end
    check("sat_final_cnt", {30'd0, bus2.event_cnt_o}, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
